// File: rtl/fhe_ntt_pkg.sv
// fhe_ntt_pkg: shared constants and types for the NTT/INTT datapath.
package fhe_ntt_pkg;
  localparam int NTT_WIDTH = 64;
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  typedef logic [NTT_WIDTH:0] ext_t;
endpackage

// File: rtl/mod_add.sv
// mod_add: combinational (a+b) mod q for a, b < q, one extra bit of headroom.
module mod_add import fhe_ntt_pkg::*; #(
  parameter int W = NTT_WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] q,
  output logic [W-1:0] y
);
  logic [W:0] s;
  assign s = {1'b0, a} + {1'b0, b};
  assign y = W'(s >= {1'b0, q} ? s - {1'b0, q} : s);
endmodule

// File: rtl/mod_sub.sv
// mod_sub: combinational (a-b) mod q for a, b < q, one extra bit of headroom.
module mod_sub import fhe_ntt_pkg::*; #(
  parameter int W = NTT_WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] q,
  output logic [W-1:0] y
);
  logic [W:0] s;
  assign s = {1'b0, a} - {1'b0, b};
  assign y = W'(a >= b ? s : s + {1'b0, q});
endmodule

// File: rtl/gs_butterfly_seq.sv
// gs_butterfly_seq: Gentleman-Sande butterfly, (a+b) mod q and (a-b)*w mod q via
// a bit-serial MSB-first interleaved modular multiplier.
module gs_butterfly_seq import fhe_ntt_pkg::*; #(
  parameter int WIDTH = NTT_WIDTH,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] w,
  input  logic [WIDTH-1:0] q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             busy
);
  state_t state, state_n;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] acc, d, q_r, w_r, sum, diff, dbl, dbl_w, t;

  mod_add #(.W(WIDTH)) u_sum (.a(a), .b(b), .q(q), .y(sum));
  mod_sub #(.W(WIDTH)) u_diff (.a(a), .b(b), .q(q), .y(diff));
  mod_add #(.W(WIDTH)) u_dbl (.a(acc), .b(acc), .q(q_r), .y(dbl));
  mod_add #(.W(WIDTH)) u_addw (.a(dbl), .b(w_r), .q(q_r), .y(dbl_w));

  // d is shifted left each iteration so its MSB is always the current bit
  assign t        = d[WIDTH-1] ? dbl_w : dbl;
  assign in_ready = state == IDLE;
  assign busy     = state != IDLE;

  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (in_valid ? MUL : IDLE) :
              state == MUL  ? (counter == '0 ? DONE : MUL) :
                              (out_ready ? IDLE : DONE);
  end

  always_ff @(posedge clk)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      acc       <= '0;
      counter   <= '0;
      d         <= '0;
      q_r       <= '0;
      w_r       <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        q_r     <= q;
        w_r     <= w;
        out_a   <= sum;
        d       <= diff;
        acc     <= '0;
        counter <= CNT_W'(WIDTH - 1);
      end
      if (state == MUL) begin
        acc     <= t;
        d       <= d << 1;
        counter <= counter - 1'b1;
        if (counter == '0) begin
          out_b     <= t;
          out_valid <= 1'b1;
        end
      end
      if (state == DONE && out_ready) out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_gs_butterfly_seq.sv
// tb_gs_butterfly_seq: scoreboard bench for the GS butterfly against a wide-arithmetic model.
module tb_gs_butterfly_seq;
  localparam int W = 64;
  typedef struct {
    logic [W-1:0] ea;
    logic [W-1:0] eb;
  } exp_t;

  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [W-1:0] a = '0, b = '0, w = '0, q = '0;
  logic in_ready, out_valid, busy;
  logic [W-1:0] out_a, out_b;
  int vectors = 0, miscompares = 0;
  exp_t sb[$];

  gs_butterfly_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .w(w), .q(q), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] ma, mb, mw, mq);
    logic [127:0] s, dd, p;
    s  = ({64'b0, ma} + {64'b0, mb}) % {64'b0, mq};
    dd = ({64'b0, ma} + {64'b0, mq} - {64'b0, mb}) % {64'b0, mq};
    p  = (dd * {64'b0, mw}) % {64'b0, mq};
    model.ea = s[W-1:0];
    model.eb = p[W-1:0];
  endfunction

  // Entered and left on a negedge; the accept happens at the posedge in between.
  task automatic send(input logic [W-1:0] sa, sb_, sw, sq);
    int n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
    end
    in_valid = 1; a = sa; b = sb_; w = sw; q = sq;
    sb.push_back(model(sa, sb_, sw, sq));
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({in_ready, busy, out_valid} !== 3'b100 || out_a !== '0 || out_b !== '0) begin
      miscompares++;
      $display("FAIL reset_state rdy/busy/vld=%b a=%h b=%h required 100 0 0",
               {in_ready, busy, out_valid}, out_a, out_b);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_basic(input logic [W-1:0] ta, tb_, tw, tq, input logic [W-1:0] xa, xb, input bit chk_lat);
    int lat;
    exp_t e;
    send(ta, tb_, tw, tq);
    vectors++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_busy busy=%b in_ready=%b required 1 0", busy, in_ready);
    end
    wait_valid(lat);
    if (chk_lat) begin
      vectors++;
      if (lat != 64) begin
        miscompares++;
        $display("FAIL basic_latency got=%0d required=64", lat);
      end
    end
    e = sb.pop_front();
    vectors++;
    if (out_valid !== 1'b1 || out_a !== xa || out_b !== xb || e.ea !== xa || e.eb !== xb) begin
      miscompares++;
      $display("FAIL basic_result vld=%b out_a=%h out_b=%h required a=%h b=%h (model %h %h)",
               out_valid, out_a, out_b, xa, xb, e.ea, e.eb);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_release vld=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure;
    int lat;
    exp_t e;
    send(64'd10, 64'd12, 64'd7, 64'd23);
    wait_valid(lat);
    e = sb.pop_front();
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; a = 64'd1; b = 64'd2; w = 64'd3; q = 64'd5;
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_a !== e.ea || out_b !== e.eb) begin
        miscompares++;
        $display("FAIL backpressure_hold cyc=%0d vld=%b rdy=%b a=%h b=%h required 1 0 %h %h",
                 i, out_valid, in_ready, out_a, out_b, e.ea, e.eb);
      end
    end
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL backpressure_release vld=%b rdy=%b required 0 1", out_valid, in_ready);
    end
    send(64'd1, 64'd1, 64'd1, 64'd17);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL backpressure_next_accept busy=%b required 1", busy);
    end
    wait_valid(lat);
    e = sb.pop_front();
    vectors++;
    if (out_a !== e.ea || out_b !== e.eb) begin
      miscompares++;
      $display("FAIL backpressure_next a=%h b=%h required %h %h", out_a, out_b, e.ea, e.eb);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_reset_mid;
    exp_t e;
    send(64'd9, 64'd4, 64'd11, 64'd13);
    repeat (19) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    void'(sb.pop_front());
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid rdy=%b busy=%b vld=%b required 1 0 0", in_ready, busy, out_valid);
    end
    repeat (80) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_no_output vld=%b required 0", out_valid);
    end
    test_basic(64'd16, 64'd16, 64'd5, 64'd17, 64'd15, 64'd0, 1'b0);
  endtask

  task automatic test_back_to_back;
    int got = 0, cyc = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [W-1:0] rq;
          rq = (i % 3 == 0) ? 64'($urandom_range(2, 1000)) : {$urandom, $urandom};
          if (rq < 2) rq = 2;
          send({$urandom, $urandom} % rq, {$urandom, $urandom} % rq, {$urandom, $urandom} % rq, rq);
          if (!in_ready && busy && cyc >= 100000) break;
        end
      end
      begin
        while (got < 1000 && cyc < 100000) begin
          bit r;
          exp_t e;
          @(negedge clk);
          cyc++;
          r = ($urandom_range(0, 3) != 0);
          out_ready = r;
          if (out_valid && r) begin
            vectors++;
            if (sb.size() == 0) begin
              miscompares++;
              $display("FAIL b2b_duplicate out_a=%h out_b=%h required no output", out_a, out_b);
            end else begin
              e = sb.pop_front();
              if (out_a !== e.ea || out_b !== e.eb) begin
                miscompares++;
                $display("FAIL b2b_result n=%0d a=%h b=%h required %h %h", got, out_a, out_b, e.ea, e.eb);
              end
            end
            got++;
          end
        end
        out_ready = 0;
      end
    join
    vectors++;
    if (got != 1000 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_count got=%0d pending=%0d required 1000 0", got, sb.size());
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_basic(64'd5, 64'd3, 64'd4, 64'd17, 64'd8, 64'd8, 1'b1);
    test_basic(64'd3, 64'd5, 64'd4, 64'd17, 64'd8, 64'd9, 1'b1);
    test_basic(64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFC4, 64'hFFFF_FFFF_FFFF_FFC5, 64'd1, 64'd1, 1'b1);
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
